// File: rtl/key_conditioner.sv
// Pushbutton/switch input conditioner: 2-flop sync, polarity normalise, debounce,
// press/release pulses and optional auto-repeat.
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 24,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_KEYS-1:0] key_raw_in,
  output logic [N_KEYS-1:0] key_level_out,
  output logic [N_KEYS-1:0] key_press_pulse,
  output logic [N_KEYS-1:0] key_release_pulse,
  output logic [N_KEYS-1:0] key_busy_out
);

  localparam logic [N_KEYS-1:0] SYNC_IDLE = (ACTIVE_LOW != 0) ? {N_KEYS{1'b1}} : {N_KEYS{1'b0}};
  localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RP_LAST   = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_db
    $error("key_conditioner: DEBOUNCE_CYCLES must be in 2..2**CNT_W-1");
  end
  if (REPEAT_CYCLES < 0 || longint'(REPEAT_CYCLES) >= (longint'(1) << CNT_W)) begin : g_bad_rp
    $error("key_conditioner: REPEAT_CYCLES must be below 2**CNT_W");
  end

  logic [N_KEYS-1:0] sync1_q;
  logic [N_KEYS-1:0] sync2_q;
  logic [N_KEYS-1:0] norm;

  // Synchronizer idles at the released pin level so reset never looks like a press.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q <= SYNC_IDLE;
      sync2_q <= SYNC_IDLE;
    end else begin
      sync1_q <= key_raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign norm = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             busy_q;
    logic             accept;

    always_comb begin
      cnt_d     = cnt_q;
      rcnt_d    = rcnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      accept    = 1'b0;

      if (norm[gi] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == DB_LAST) begin
        accept    = 1'b1;
        cnt_d     = '0;
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end

      // Repeat timer only runs while the accepted level is held pressed.
      if (REPEAT_CYCLES == 0 || accept || !level_q) begin
        rcnt_d = '0;
      end else if (rcnt_q == RP_LAST) begin
        rcnt_d  = '0;
        press_d = 1'b1;
      end else begin
        rcnt_d = rcnt_q + CNT_ONE;
      end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
        cnt_q     <= '0;
        rcnt_q    <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        rcnt_q    <= rcnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        busy_q    <= (cnt_d != '0);
      end
    end

    assign key_level_out[gi]     = level_q;
    assign key_press_pulse[gi]   = press_q;
    assign key_release_pulse[gi] = release_q;
    assign key_busy_out[gi]      = busy_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: one instance without repeat, one with REPEAT_CYCLES=10.
module tb_key_conditioner;

  logic       clk;
  logic       rst_n;
  logic [2:0] raw_a, raw_b;
  logic [2:0] lvl_a, prs_a, rel_a, bsy_a;
  logic [2:0] lvl_b, prs_b, rel_b, bsy_b;
  logic [2:0] seen;
  int         checks;
  int         fails;

  key_conditioner #(
    .N_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(24), .ACTIVE_LOW(1)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .key_raw_in(raw_a),
    .key_level_out(lvl_a), .key_press_pulse(prs_a),
    .key_release_pulse(rel_a), .key_busy_out(bsy_a)
  );

  key_conditioner #(
    .N_KEYS(3), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(10), .CNT_W(24), .ACTIVE_LOW(1)
  ) dut_rep (
    .clk_clk(clk), .reset_reset_n(rst_n), .key_raw_in(raw_b),
    .key_level_out(lvl_b), .key_press_pulse(prs_b),
    .key_release_pulse(rel_b), .key_busy_out(bsy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst_n  = 1'b0;
    raw_a  = 3'b111;
    raw_b  = 3'b111;
    seen   = 3'b000;

    #2;
    chk("rst_level", lvl_a, 3'b000);
    chk("rst_press", prs_a, 3'b000);
    chk("rst_release", rel_a, 3'b000);
    chk("rst_busy", bsy_a, 3'b000);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("idle_level", lvl_a, 3'b000);
    chk("idle_busy", bsy_a, 3'b000);
    $display("reset/idle checks done");

    // Clean press and release on channel 0
    raw_a[0] = 1'b0;
    tick(5);
    chk("press_early_level", lvl_a, 3'b000);
    tick(1);
    chk("press_level", lvl_a, 3'b001);
    chk("press_pulse", prs_a, 3'b001);
    chk("press_no_release", rel_a, 3'b000);
    tick(1);
    chk("press_pulse_end", prs_a, 3'b000);
    chk("press_hold_level", lvl_a, 3'b001);
    tick(13);
    raw_a[0] = 1'b1;
    tick(5);
    chk("release_early_level", lvl_a, 3'b001);
    tick(1);
    chk("release_level", lvl_a, 3'b000);
    chk("release_pulse", rel_a, 3'b001);
    chk("release_no_press", prs_a, 3'b000);
    tick(1);
    chk("release_pulse_end", rel_a, 3'b000);
    $display("clean press/release ch0 done");

    // Bounce on channel 1
    seen = 3'b000;
    for (int step = 0; step < 4; step++) begin
      raw_a[1] = (step % 2 == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < 2; c++) begin
        tick(1);
        seen |= prs_a | rel_a;
      end
    end
    raw_a[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(1);
      seen |= prs_a | rel_a;
    end
    chk("bounce_no_pulse", seen, 3'b000);
    chk("bounce_early_level", lvl_a, 3'b000);
    tick(1);
    chk("bounce_press", prs_a, 3'b010);
    chk("bounce_level", lvl_a, 3'b010);
    tick(1);
    chk("bounce_press_end", prs_a, 3'b000);
    raw_a[1] = 1'b1;
    tick(7);
    chk("bounce_released", lvl_a, 3'b000);
    $display("bounce ch1 done");

    // Three-cycle glitch on channel 2
    seen = 3'b000;
    raw_a[2] = 1'b0;
    tick(3);
    chk("glitch_busy_hi", bsy_a, 3'b100);
    seen |= prs_a | rel_a;
    raw_a[2] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      seen |= prs_a | rel_a;
    end
    chk("glitch_no_pulse", seen, 3'b000);
    chk("glitch_level", lvl_a, 3'b000);
    chk("glitch_busy_clr", bsy_a, 3'b000);
    $display("glitch ch2 done");

    // Simultaneous press on channels 0 and 2
    raw_a = 3'b010;
    tick(5);
    chk("simul_early", lvl_a, 3'b000);
    tick(1);
    chk("simul_level", lvl_a, 3'b101);
    chk("simul_press", prs_a, 3'b101);
    tick(1);
    chk("simul_press_end", prs_a, 3'b000);
    raw_a = 3'b111;
    tick(6);
    chk("simul_release", rel_a, 3'b101);
    chk("simul_rel_level", lvl_a, 3'b000);
    tick(1);
    chk("simul_release_end", rel_a, 3'b000);
    $display("simultaneous ch0+ch2 done");

    // Auto-repeat on the REPEAT_CYCLES=10 instance
    raw_b[0] = 1'b0;
    tick(6);
    chk("rep_accept_level", lvl_b, 3'b001);
    chk("rep_accept_press", prs_b, 3'b001);
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      chk($sformatf("rep_press_%0d", i), prs_b, (i % 10 == 0) ? 3'b001 : 3'b000);
    end
    raw_b[0] = 1'b1;
    for (int i = 41; i <= 45; i++) begin
      tick(1);
      chk($sformatf("rep_tail_%0d", i), prs_b, 3'b000);
    end
    tick(1);
    chk("rep_release_pulse", rel_b, 3'b001);
    chk("rep_release_level", lvl_b, 3'b000);
    chk("rep_release_no_press", prs_b, 3'b000);
    seen = 3'b000;
    for (int c = 0; c < 15; c++) begin
      tick(1);
      seen |= prs_b | rel_b;
    end
    chk("rep_quiet_after", seen, 3'b000);
    $display("auto-repeat done");

    // Asynchronous reset while all keys held, then re-debounce
    raw_a = 3'b000;
    tick(6);
    chk("hold_all_level", lvl_a, 3'b111);
    chk("hold_all_press", prs_a, 3'b111);
    tick(3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_level", lvl_a, 3'b000);
    chk("async_rst_press", prs_a, 3'b000);
    chk("async_rst_busy", bsy_a, 3'b000);
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("post_rst_early", lvl_a, 3'b000);
    tick(1);
    chk("post_rst_level", lvl_a, 3'b111);
    chk("post_rst_press", prs_a, 3'b111);
    tick(1);
    chk("post_rst_press_end", prs_a, 3'b000);
    chk("post_rst_hold", lvl_a, 3'b111);
    $display("reset mid-hold done");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
